// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// The FSM state encoding and the data word width live here.
package mem_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/tridrive.sv
// Generic tri-state bus driver: drives 'data' onto 'bus' while 'en' is high,
// otherwise leaves the bus floating.
module tridrive #(
    parameter int WIDTH = 16
) (
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    inout  wire  [WIDTH-1:0] bus
);

    assign bus = en ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder on a shared bidirectional data bus.
// Optional addrErr output is enabled with macro MEM_RESPONDER_ADDR_ERR_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic [15:0]       memAddr,
    inout  wire  [WORD_W-1:0] dataBus,
    input  logic              re_L,
    input  logic              we_L,
    output logic              ready
`ifdef MEM_RESPONDER_ADDR_ERR_EN
    ,
    output logic              addrErr
`endif
);

    localparam int         ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state;
    state_t              state_next;
    logic [3:0]          wait_cnt;
    logic [3:0]          cnt_next;
    logic                accept;
    logic                req_dropped;

    logic [ADDR_W-1:0]   lat_idx;
    logic                lat_re;
    logic                lat_we;
    logic                lat_oor;
    logic [WORD_W-1:0]   lat_data;

    logic [WORD_W-1:0]   mem [DEPTH];

    logic [14:0]         word_idx;
    logic                addr_oor;
    logic                unused_addr_bit;
    logic                commit;
    logic                drive_en;
    logic [WORD_W-1:0]   rd_data;

    assign word_idx        = memAddr[15:1];
    assign unused_addr_bit = memAddr[0];
    assign addr_oor        = ({17'd0, word_idx} >= 32'(DEPTH));

    // A request is dropped if any signal that was low at acceptance has since risen.
    assign req_dropped = (lat_re && re_L) || (lat_we && we_L);

    always_comb begin
        state_next = state;
        cnt_next   = wait_cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!re_L || !we_L) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next = BUSY;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            BUSY: begin
                if (req_dropped) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
        end
    end

    // Request attributes are frozen at acceptance; later address/bus activity is ignored.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            lat_idx  <= '0;
            lat_re   <= 1'b0;
            lat_we   <= 1'b0;
            lat_oor  <= 1'b0;
            lat_data <= '0;
        end else if (accept) begin
            lat_idx <= word_idx[ADDR_W-1:0];
            lat_re  <= !re_L;
            lat_we  <= !we_L;
            lat_oor <= addr_oor;
            if (re_L) begin
                lat_data <= dataBus;
            end
        end
    end

    assign commit = (state == RESP) && lat_we && !lat_re && !lat_oor;

    // Storage is deliberately not reset; only a completed legal write changes it.
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[lat_idx] <= lat_data;
        end
    end

    assign rd_data  = (lat_we || lat_oor) ? '0 : mem[lat_idx];
    assign drive_en = (state == RESP) && lat_re && !re_L;
    assign ready    = (state == RESP);

`ifdef MEM_RESPONDER_ADDR_ERR_EN
    assign addrErr = (state == RESP) && (lat_oor || (lat_re && lat_we));
`endif

    tridrive #(
        .WIDTH(WORD_W)
    ) u_drive (
        .en  (drive_en),
        .data(rd_data),
        .bus (dataBus)
    );

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 16-bit words stored (power of two, max 32768).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before the response (0..15).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_L, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port memAddr, input, 16, byte address; bit 0 ignored, word index = memAddr[15:1].
REQ-006 SHALL have port dataBus, inout, 16, shared data bus driven by the initiator on writes and by this block on reads.
REQ-007 SHALL have port re_L, input, 1, active-low read request.
REQ-008 SHALL have port we_L, input, 1, active-low write request.
REQ-009 SHALL have port ready, output, 1, one-cycle response strobe.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-011 SHALL, in IDLE, accept a request when exactly one of re_L or we_L is low at a clock edge, latching word index, direction and (for writes) dataBus.
REQ-012 SHALL go IDLE->BUSY on acceptance when WAIT_CYCLES>0, else IDLE->RESP directly.
REQ-013 SHALL count WAIT_CYCLES edges in BUSY, then enter RESP; ready high exactly in RESP, so it is high in the cycle after edge WAIT_CYCLES+1 (counting the acceptance edge as 1).
REQ-014 SHALL, in RESP for a read, drive dataBus with the stored word; dataBus SHALL be high-Z in every other state and whenever re_L is high.
REQ-015 SHALL commit a write to the array at the RESP->IDLE edge using the data latched at acceptance.
REQ-016 SHALL leave RESP for IDLE after one cycle unconditionally; a new request is accepted no earlier than the following edge.
REQ-017 SHALL treat re_L and we_L both low in IDLE as illegal: no array access, enter RESP after the normal latency, read data 16'h0000, ready pulsed.
REQ-018 SHALL abort to IDLE, with no write committed and ready low, if the latched request signal deasserts while in BUSY.
REQ-019 SHALL ignore memAddr and dataBus changes after acceptance.
REQ-020 SHALL, for word index >= DEPTH, return 16'h0000 on reads and discard writes, with normal latency.

Reset
REQ-021 SHALL, while reset_L is low, force state IDLE, wait counter 0, ready 0 and dataBus high-Z, independent of clock.
REQ-022 SHALL discard any in-flight request on reset, with no write committed; array contents are not cleared by reset.

Configuration
REQ-023 SHALL, with macro MEM_RESPONDER_ADDR_ERR_EN defined, add output port addrErr (1 bit, reset 0), high in RESP only for out-of-range or illegal (REQ-017) requests.
REQ-024 SHALL, without MEM_RESPONDER_ADDR_ERR_EN, omit addrErr entirely, with all other behaviour unchanged.

Structure
REQ-025 SHALL place the FSM state enum (IDLE/BUSY/RESP) and the word width constant (16) in shared package mem_pkg.
REQ-026 SHALL drive dataBus through the existing codebase tridrive module (WIDTH 16); no other sub-module.

Verification
REQ-027 SHALL cover: WAIT_CYCLES=2; write 16'hBEEF to memAddr 16'h0010 -> ready on the 3rd cycle after acceptance; a later read of 16'h0010 -> dataBus=16'hBEEF during ready only, Z otherwise.
REQ-028 SHALL cover: WAIT_CYCLES=0; back-to-back reads of 16'h0000 and 16'h0002 -> ready one cycle after each acceptance, exactly one idle cycle between accepts.
REQ-029 SHALL cover: write 16'h1234 to 16'h0020, deassert we_L in BUSY -> no ready; a read of 16'h0020 returns the prior contents.
REQ-030 SHALL cover: re_L and we_L low together -> ready pulses, dataBus=16'h0000 (Z unless re_L is low), no array change, addrErr=1 when enabled.
REQ-031 SHALL cover: DEPTH=256; read memAddr 16'h0200 -> data 16'h0000, addrErr=1 when enabled; a write there leaves word 0 unchanged.
REQ-032 SHALL cover: reset_L low mid-BUSY on a write -> ready=0 and bus Z immediately, state IDLE, target word unchanged.
